mux41_rr_arb: RTL and testbench



---
 rtl/mux41_rr_arb.sv | 151 +++++++++++++++
 tb/tb_mux41_rr_arb.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mux41_rr_arb.sv
// mux41_rr_arb: four-requester round-robin arbiter that owns the select of a
// shared 4:1 single-bit mux. Grant, select and valid are registered; y is the
// combinational mux output (a[s] while valid, else 0).
//
// Optional build macro: MUX41_RR_ARB_TIMEOUT_EN
//   defined   - an owner holding the mux for MAX_HOLD consecutive cycles is
//               released when another source is waiting.
//   undefined - no hold counter; the owner keeps the mux until it drops req.
//
// state | meaning
// IDLE  | nobody owns the mux; gnt=0, valid=0, s holds its last value
// GRANT | source s owns the mux; gnt=1<<s, valid=1

module mux41_rr_arb #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] a,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       valid,
  output logic       y
);

  localparam bit CFG_OK = (MAX_HOLD >= 2) && (MAX_HOLD <= 255) &&
                          ((2 ** CNT_W) > MAX_HOLD);

  // Reject parameter sets the hold counter cannot represent.
  if (!CFG_OK) begin : g_bad_cfg
    $error("mux41_rr_arb: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] s_q, s_d;
  logic       valid_q, valid_d;
  logic [1:0] last_q, last_d;
  logic       take;
  logic [1:0] win;
`ifdef MUX41_RR_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       others;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
`endif

  // First requester in r searching base+1, base+2, base+3, base (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Next-state, arbitration and hold-counter logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    valid_d = valid_q;
    last_d  = last_q;
    take    = 1'b0;
    win     = 2'd0;
`ifdef MUX41_RR_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    others  = req & ~gnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          take = 1'b1;
          win  = rr_pick(req, last_q);
        end
      end
      GRANT: begin
        if (req[s_q]) begin
`ifdef MUX41_RR_ARB_TIMEOUT_EN
          if ((cnt_q == HOLD_LAST) && (|others)) begin
            take = 1'b1;
            win  = rr_pick(others, s_q);
          end else if (cnt_q != HOLD_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end else if (|req) begin
          // Owner dropped with others waiting: hand over without a bubble.
          take = 1'b1;
          win  = rr_pick(req, s_q);
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = GRANT;
      s_d     = win;
      gnt_d   = 4'b0001 << win;
      valid_d = 1'b1;
      last_d  = win;
`ifdef MUX41_RR_ARB_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end
  end

  // State and output registers; pointer resets to 3 so source 0 goes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      s_q     <= 2'd0;
      valid_q <= 1'b0;
      last_q  <= 2'd3;
`ifdef MUX41_RR_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef MUX41_RR_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Mux output: selected source bit, forced low while idle.
  always_comb begin
    y = valid_q ? a[s_q] : 1'b0;
  end

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux41_rr_arb.sv
// Directed bench for mux41_rr_arb with hand-computed expectations.
// Built with MUX41_RR_ARB_TIMEOUT_EN defined, the hold-limit vectors expect
// rotation every MAX_HOLD=4 cycles; otherwise the owner keeps the grant.

module tb_mux41_rr_arb;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] a;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       valid;
  logic       y;

  int n_chk;
  int n_pass;

  mux41_rr_arb #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .a     (a),
    .gnt   (gnt),
    .s     (s),
    .valid (valid),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_own(input string tag, input int o);
    logic [3:0] g;
    g = 4'b0001 << o;
    chk({tag, "_gnt"}, 8'(gnt), 8'(g));
    chk({tag, "_s"}, 8'(s), 8'(o));
    chk({tag, "_valid"}, 8'(valid), 8'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, 8'(gnt), 8'd0);
    chk({tag, "_valid"}, 8'(valid), 8'd0);
    chk({tag, "_y"}, 8'(y), 8'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst = 1'b1;
    req = 4'b0000;
    a   = 4'b1111;
    tick();
    tick();
    chk_idle("por");
    chk("por_s", 8'(s), 8'd0);

    // reset mid-grant
    rst = 1'b0;
    req = 4'b1111;
    tick();
    chk_own("first", 0);
    chk("first_y", 8'(y), 8'd1);
    tick();
    chk_own("hold0", 0);
    rst = 1'b1;
    #1;
    chk_idle("midrst");
    chk("midrst_s", 8'(s), 8'd0);
    rst = 1'b0;
    tick();
    chk_own("postrst", 0);

    // rotation 0,1,2,3,0 with 2-cycle ownership and no valid gap
    for (int k = 0; k < 5; k++) begin
      chk_own($sformatf("rot%0d_c1", k), k % 4);
      if (k == 4) break;
      tick();
      chk_own($sformatf("rot%0d_c2", k), k % 4);
      req = 4'b1111 & ~(4'b0001 << k);
      tick();
      req = 4'b1111;
    end
    req = 4'b0000;
    tick();
    chk_idle("rot_end");
    chk("rot_end_s", 8'(s), 8'd0);

    // single requester, y follows a[2] combinationally
    req = 4'b0100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_own($sformatf("single_c%0d", i), 2);
      a = 4'b1011;
      #1;
      chk($sformatf("single_y0_c%0d", i), 8'(y), 8'd0);
      a = 4'b0100;
      #1;
      chk($sformatf("single_y1_c%0d", i), 8'(y), 8'd1);
    end
    req = 4'b0000;
    tick();
    chk_idle("single_drop");
    chk("single_drop_s", 8'(s), 8'd2);

    // pointer fairness
    req = 4'b1000;
    tick();
    chk_own("fair_src3", 3);
    req = 4'b0000;
    tick();
    chk_idle("fair_rel3");
    req = 4'b1001;
    tick();
    chk_own("fair_to0", 0);
    req = 4'b0000;
    tick();
    chk_idle("fair_rel0");
    req = 4'b1001;
    tick();
    chk_own("fair_to3", 3);
    req = 4'b0000;
    tick();
    chk_idle("fair_rel3b");

    // idle masking
    a = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle($sformatf("mask_c%0d", i));
    end

    // two constant requesters
    req = 4'b0011;
    for (int i = 1; i <= 16; i++) begin
      tick();
`ifdef MUX41_RR_ARB_TIMEOUT_EN
      chk_own($sformatf("hold2_c%0d", i), ((i - 1) / 4) % 2);
`else
      chk_own($sformatf("hold2_c%0d", i), 0);
`endif
    end
    req = 4'b0000;
    tick();
    chk_idle("hold2_rel");

    // lone requester is never preempted
    req = 4'b0001;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_own($sformatf("lone_c%0d", i), 0);
    end
    req = 4'b0000;
    tick();
    chk_idle("lone_rel");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
